// File: rtl/ntt_poly_tx.sv
// Double-buffered polynomial transmitter: two ping-pong coefficient banks, streamed as N/2
// contiguous two-coefficient beats in NTT (k, k+N/2) or INTT (2k, 2k+1) order.
module ntt_poly_tx #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [$clog2(N)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit,
  input  logic                  mode,
  output logic                  wr_ready,
  output logic                  out_en,
  output logic [DATA_WIDTH-1:0] out [2],
  output logic                  done,
  output logic                  overflow
);

  localparam int AW = $clog2(N);
  localparam int KW = AW - 1;
  localparam logic [KW-1:0] KLAST = KW'(N / 2 - 1);

  typedef enum logic [1:0] {BkEmpty, BkReady, BkSending} bank_e;
  typedef enum logic {StIdle, StSend} state_e;

  logic [DATA_WIDTH-1:0] mem0 [N];
  logic [DATA_WIDTH-1:0] mem1 [N];

  bank_e                 bank_st   [2];
  logic                  bank_mode [2];
  logic                  wbank;
  logic                  rbank;
  state_e                state;
  logic [KW-1:0]         k;

  // Read stage: memory output register, one cycle ahead of the out registers.
  logic [DATA_WIDTH-1:0] rd [2];
  logic                  rd_vld;
  logic                  rd_last;

  logic                  wr_ok;
  logic                  commit_ok;
  logic                  start;
  logic                  last;
  logic                  issue;
  logic                  other_ready;
  logic [KW-1:0]         rk;
  logic [AW-1:0]         addr0;
  logic [AW-1:0]         addr1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  always_comb begin
    wr_ready  = (bank_st[wbank] == BkEmpty);
    wr_ok     = wr_en && wr_ready;
    commit_ok = commit && wr_ready;
    // An IDLE cycle that finds a READY bank already issues the read for beat 0.
    start     = (state == StIdle) && (bank_st[rbank] == BkReady);
    last      = (state == StSend) && (k == KLAST);
    issue     = start || (state == StSend);
    rk        = start ? '0 : k;
    // A commit landing on the same edge as the last read still chains without a gap.
    other_ready = (bank_st[~rbank] == BkReady) || (commit_ok && (wbank != rbank));
    if (bank_mode[rbank]) begin
      addr0 = {rk, 1'b0};
      addr1 = {rk, 1'b1};
    end else begin
      addr0 = {1'b0, rk};
      addr1 = {1'b1, rk};
    end
    rdata0 = rbank ? mem1[addr0] : mem0[addr0];
    rdata1 = rbank ? mem1[addr1] : mem0[addr1];
  end

  // Coefficient storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wbank) mem1[wr_addr] <= wr_data;
      else       mem0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0]   <= BkEmpty;
      bank_st[1]   <= BkEmpty;
      bank_mode[0] <= 1'b0;
      bank_mode[1] <= 1'b0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      state        <= StIdle;
      k            <= '0;
      overflow     <= 1'b0;
    end else begin
      if ((wr_en || commit) && !wr_ready) overflow <= 1'b1;

      if (commit_ok) begin
        bank_st[wbank]   <= BkReady;
        bank_mode[wbank] <= mode;
        wbank            <= ~wbank;
      end

      // Later assignments win: a chained bank goes SENDING even if committed this edge.
      case (state)
        StIdle: begin
          if (start) begin
            bank_st[rbank] <= BkSending;
            state          <= StSend;
            k              <= KW'(1);
          end
        end
        StSend: begin
          if (last) begin
            bank_st[rbank] <= BkEmpty;
            rbank          <= ~rbank;
            k              <= '0;
            if (other_ready) bank_st[~rbank] <= BkSending;
            else             state           <= StIdle;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd[0]   <= '0;
      rd[1]   <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      out[0]  <= '0;
      out[1]  <= '0;
      out_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_last <= last;
      rd[0]   <= issue ? rdata0 : '0;
      rd[1]   <= issue ? rdata1 : '0;
      out_en  <= rd_vld;
      done    <= rd_vld && rd_last;
      out[0]  <= rd_vld ? rd[0] : '0;
      out[1]  <= rd_vld ? rd[1] : '0;
    end
  end

endmodule

// File: tb/tb_ntt_poly_tx.sv
// Randomized bench for ntt_poly_tx: a polynomial-level model predicts every beat, done,
// wr_ready and overflow from commit times, snapshotted bank contents and the chaining rule.
module tb_ntt_poly_tx;

  localparam int DW   = 12;
  localparam int N    = 256;
  localparam int AW   = $clog2(N);
  localparam int MAXP = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          commit = 1'b0;
  logic          mode = 1'b0;
  logic          wr_ready;
  logic          out_en;
  logic [DW-1:0] dout [2];
  logic          done;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  // Model: bank contents, write-bank pointer and the list of accepted polynomials.
  logic [DW-1:0] mmem [2][N];
  bit            mwb = 1'b0;
  logic [DW-1:0] pdat [MAXP][N];
  bit            pmode [MAXP];
  int            pcommit [MAXP];
  int            pstart [MAXP];
  int            np = 0;
  int            live = 0;
  int            ovf_edge = -1;

  ntt_poly_tx #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .commit   (commit),
    .mode     (mode),
    .wr_ready (wr_ready),
    .out_en   (out_en),
    .out      (dout),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // A bank is held from its commit edge until the edge issuing its last read.
  function automatic bit m_wr_ready(input int ee);
    int cnt = 0;
    for (int p = live; p < np; p++)
      if (pcommit[p] <= ee && ee < pstart[p] + N / 2 - 2) cnt++;
    return cnt < 2;
  endfunction

  always @(negedge clk) begin
    logic [DW-1:0] x0, x1;
    bit en, dn;
    int kk;
    en = 0; dn = 0; x0 = '0; x1 = '0;
    for (int p = live; p < np; p++) begin
      if (e >= pstart[p] && e < pstart[p] + N / 2) begin
        kk = e - pstart[p];
        en = 1;
        dn = (kk == N / 2 - 1);
        if (pmode[p]) begin
          x0 = pdat[p][2 * kk];
          x1 = pdat[p][2 * kk + 1];
        end else begin
          x0 = pdat[p][kk];
          x1 = pdat[p][kk + N / 2];
        end
      end
    end
    check_eq("out_en", 32'(out_en), 32'(en));
    check_eq("out0", 32'(dout[0]), 32'(x0));
    check_eq("out1", 32'(dout[1]), 32'(x1));
    check_eq("done", 32'(done), 32'(dn));
    check_eq("wr_ready", 32'(wr_ready), 32'(m_wr_ready(e)));
    check_eq("overflow", 32'(overflow), 32'(ovf_edge >= 0 && e >= ovf_edge));
  end

  // Drive one cycle of inputs (called just after a rising edge) and update the model.
  task automatic cyc(input bit we, input int a, input int d, input bit cm, input bit md);
    bit acc;
    int s;
    wr_en   = we;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    commit  = cm;
    mode    = md;
    acc = m_wr_ready(e);
    if ((we || cm) && !acc && ovf_edge < 0) ovf_edge = e + 1;
    if (we && acc) mmem[mwb][a] = DW'(d);
    if (cm && acc && np < MAXP) begin
      for (int i = 0; i < N; i++) pdat[np][i] = mmem[mwb][i];
      pmode[np]   = md;
      pcommit[np] = e + 1;
      s = e + 3;
      if (np > live && pstart[np-1] + N / 2 > s) s = pstart[np-1] + N / 2;
      pstart[np] = s;
      np++;
      mwb = ~mwb;
    end
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, hold 3 edges, release.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    live = np;
    ovf_edge = -1;
    mwb = 1'b0;
    #1;
    check_eq("rst_out_en", 32'(out_en), 32'd0);
    check_eq("rst_out0", 32'(dout[0]), 32'd0);
    check_eq("rst_out1", 32'(dout[1]), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int nw;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    do_reset();
    idle(5);

    // NTT pair order: c[i]=i, mode 0.
    for (int i = 0; i < N; i++) cyc(1, i, i, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(140);

    // INTT adjacent-pair order on the other bank.
    for (int i = 0; i < N; i++) cyc(1, i, i, 0, 0);
    cyc(0, 0, 0, 1, 1);
    idle(140);

    // Back-to-back: A reuses stale bank contents, B is loaded and committed during A's stream.
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) cyc(1, i, 1000 + i, 0, 0);
    cyc(1, 100, 1100, 1, 0);
    idle(300);

    // Random traffic: partial loads, random modes, random commit timing and gaps.
    for (int r = 0; r < 14; r++) begin
      nw = $urandom_range(0, 180);
      for (int i = 0; i < nw; i++)
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, N - 1), $urandom_range(0, 4095), 0, 0);
      cyc($urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, 4095), 1,
          $urandom_range(0, 1));
      idle($urandom_range(0, 150));
    end
    idle(300);

    // Reset in the middle of a stream, then a fresh polynomial.
    cyc(0, 0, 0, 1, 0);
    while (e < pstart[np-1] + 50) idle(1);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, $urandom_range(0, N - 1), $urandom_range(0, 4095), 0, 0);
    cyc(0, 0, 0, 1, 1);
    idle(140);

    // Overflow: A sending, B ready, then a write plus commit that must be dropped.
    for (int i = 0; i < 10; i++) cyc(1, i, $urandom_range(0, 4095), 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 5; i++) cyc(1, i, $urandom_range(0, 4095), 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 5, 'hABC, 1, 0);
    idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
